// File: rtl/tcp_rx_seg_accept_if.sv
// Segment-in / result-out handshake bundle for tcp_rx_seg_accept.
// The slave modport is the acceptance engine; the master modport is its surrounding parser/scheduler.
interface tcp_rx_seg_accept_if #(
  parameter int FLOWID_W = 8,
  parameter int RX_PTR_W = 14,
  parameter int LEN_W    = 16,
  parameter int ADDR_W   = 32
);
  logic                in_val;
  logic                in_rdy;
  logic [FLOWID_W-1:0] in_flowid;
  logic [31:0]         in_seq_num;
  logic [ADDR_W-1:0]   in_payload_addr;
  logic [LEN_W-1:0]    in_payload_len;

  logic                out_val;
  logic                out_rdy;
  logic [FLOWID_W-1:0] out_flowid;
  logic                out_accept;
  logic [LEN_W-1:0]    out_len;
  logic [ADDR_W-1:0]   out_payload_addr;
  logic                out_ack_pend;
  logic [31:0]         out_their_ack;
  logic [RX_PTR_W:0]   out_our_win;

  modport master (
    output in_val, in_flowid, in_seq_num, in_payload_addr, in_payload_len,
    input  in_rdy,
    input  out_val, out_flowid, out_accept, out_len, out_payload_addr,
           out_ack_pend, out_their_ack, out_our_win,
    output out_rdy
  );

  modport slave (
    input  in_val, in_flowid, in_seq_num, in_payload_addr, in_payload_len,
    output in_rdy,
    output out_val, out_flowid, out_accept, out_len, out_payload_addr,
           out_ack_pend, out_their_ack, out_our_win,
    input  out_rdy
  );
endinterface

// File: rtl/tcp_rx_seg_accept.sv
// Three-stage pipelined TCP receive acceptance engine with per-flow ack/tail forwarding.
// Optional: define TCP_RX_TRIM_EN to partially accept in-order segments that overrun the window.
module tcp_rx_seg_accept #(
  parameter int FLOWID_W = 8,
  parameter int RX_PTR_W = 14,
  parameter int LEN_W    = 16,
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  tcp_rx_seg_accept_if.slave  bus_if,
  output logic [FLOWID_W-1:0] st_rd_addr,
  input  logic [31:0]         st_rd_ack,
  input  logic [RX_PTR_W:0]   st_rd_tail,
  input  logic [RX_PTR_W:0]   st_rd_head,
  output logic                st_wr_val,
  output logic [FLOWID_W-1:0] st_wr_addr,
  output logic [31:0]         st_wr_ack,
  output logic [RX_PTR_W:0]   st_wr_tail,
  output logic [CNT_W-1:0]    stat_accept_cnt,
  output logic [CNT_W-1:0]    stat_drop_cnt
);
  localparam int PTR_W = RX_PTR_W + 1;
  localparam int CMP_W = (LEN_W > PTR_W) ? LEN_W : PTR_W;
  localparam logic [PTR_W-1:0] BUF_SIZE = {1'b1, {RX_PTR_W{1'b0}}};

  // S1: segment fields plus the held memory response
  logic                s1_vld_q, s1_new_q;
  logic [FLOWID_W-1:0] s1_flowid_q;
  logic [31:0]         s1_seq_q;
  logic [ADDR_W-1:0]   s1_addr_q;
  logic [LEN_W-1:0]    s1_len_q;
  logic [31:0]         s1_ack_q;
  logic [PTR_W-1:0]    s1_tail_q, s1_head_q;

  // S2: output register, also the source of the state write
  logic                s2_vld_q, s2_accept_q, s2_pend_q, s2_drop_q;
  logic [FLOWID_W-1:0] s2_flowid_q;
  logic [LEN_W-1:0]    s2_len_q;
  logic [ADDR_W-1:0]   s2_addr_q;
  logic [31:0]         s2_ack_q;
  logic [PTR_W-1:0]    s2_tail_q, s2_win_q;

  // Last write, covering the read that collided with it
  logic                lw_vld_q;
  logic [FLOWID_W-1:0] lw_flowid_q;
  logic [31:0]         lw_ack_q;
  logic [PTR_W-1:0]    lw_tail_q;

  logic [CNT_W-1:0]    acc_cnt_q, drop_cnt_q;

  logic in_rdy, s0_fire, s1_adv, s2_fire;

  assign s2_fire = s2_vld_q && bus_if.out_rdy;
  assign s1_adv  = s1_vld_q && (!s2_vld_q || bus_if.out_rdy);
  assign in_rdy  = !rst && !(s1_vld_q && s2_vld_q && !bus_if.out_rdy);
  assign s0_fire = bus_if.in_val && in_rdy;

  assign bus_if.in_rdy = in_rdy;
  assign st_rd_addr    = rst ? '0 : bus_if.in_flowid;

  logic [31:0]      cur_ack, fwd_ack, new_ack;
  logic [PTR_W-1:0] cur_tail, cur_head, fwd_tail, new_tail;
  logic [PTR_W-1:0] used, win, new_win;
  logic [LEN_W-1:0] acc_len;
  logic             match, has_len, accept, drop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cur_ack  = s1_ack_q;
    cur_tail = s1_tail_q;
    cur_head = s1_head_q;
    if (s1_new_q) begin
      cur_head = st_rd_head;
      if (lw_vld_q && (lw_flowid_q == s1_flowid_q)) begin
        cur_ack  = lw_ack_q;
        cur_tail = lw_tail_q;
      end else begin
        cur_ack  = st_rd_ack;
        cur_tail = st_rd_tail;
      end
    end

    // The segment retiring this cycle is the newest state for its flow
    fwd_ack  = cur_ack;
    fwd_tail = cur_tail;
    if (s2_fire && (s2_flowid_q == s1_flowid_q)) begin
      fwd_ack  = s2_ack_q;
      fwd_tail = s2_tail_q;
    end

    used    = fwd_tail - cur_head;
    win     = BUF_SIZE - used;
    match   = (s1_seq_q == fwd_ack);
    has_len = (s1_len_q != '0);
    accept  = 1'b0;
    acc_len = '0;
    if (match && has_len && (CMP_W'(s1_len_q) <= CMP_W'(win))) begin
      accept  = 1'b1;
      acc_len = s1_len_q;
    end
`ifdef TCP_RX_TRIM_EN
    else if (match && has_len && (win != '0)) begin
      accept  = 1'b1;
      acc_len = LEN_W'(win);
    end
`endif
    drop     = has_len && !accept;
    new_ack  = fwd_ack + 32'(acc_len);
    new_tail = fwd_tail + PTR_W'(acc_len);
    new_win  = win - PTR_W'(acc_len);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      s1_new_q    <= 1'b0;
      s1_flowid_q <= '0;
      s1_seq_q    <= '0;
      s1_addr_q   <= '0;
      s1_len_q    <= '0;
      s1_ack_q    <= '0;
      s1_tail_q   <= '0;
      s1_head_q   <= '0;
      s2_vld_q    <= 1'b0;
      s2_accept_q <= 1'b0;
      s2_pend_q   <= 1'b0;
      s2_drop_q   <= 1'b0;
      s2_flowid_q <= '0;
      s2_len_q    <= '0;
      s2_addr_q   <= '0;
      s2_ack_q    <= '0;
      s2_tail_q   <= '0;
      s2_win_q    <= '0;
      lw_vld_q    <= 1'b0;
      lw_flowid_q <= '0;
      lw_ack_q    <= '0;
      lw_tail_q   <= '0;
      acc_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge value of its neighbour.
      if (s0_fire) begin
        s1_vld_q    <= 1'b1;
        s1_new_q    <= 1'b1;
        s1_flowid_q <= bus_if.in_flowid;
        s1_seq_q    <= bus_if.in_seq_num;
        s1_addr_q   <= bus_if.in_payload_addr;
        s1_len_q    <= bus_if.in_payload_len;
      end else if (s1_adv) begin
        s1_vld_q <= 1'b0;
        s1_new_q <= 1'b0;
      end else if (s1_vld_q && s1_new_q) begin
        // Stalled: the memory response is only valid for one cycle, so hold it
        s1_new_q  <= 1'b0;
        s1_ack_q  <= cur_ack;
        s1_tail_q <= cur_tail;
        s1_head_q <= cur_head;
      end

      if (s1_adv) begin
        s2_vld_q    <= 1'b1;
        s2_accept_q <= accept;
        s2_pend_q   <= has_len;
        s2_drop_q   <= drop;
        s2_flowid_q <= s1_flowid_q;
        s2_len_q    <= acc_len;
        s2_addr_q   <= s1_addr_q;
        s2_ack_q    <= new_ack;
        s2_tail_q   <= new_tail;
        s2_win_q    <= new_win;
      end else if (s2_fire) begin
        s2_vld_q <= 1'b0;
      end

      lw_vld_q <= s2_fire;
      if (s2_fire) begin
        lw_flowid_q <= s2_flowid_q;
        lw_ack_q    <= s2_ack_q;
        lw_tail_q   <= s2_tail_q;
      end

      if (s2_fire && s2_accept_q && (acc_cnt_q != '1))
        acc_cnt_q <= acc_cnt_q + CNT_W'(1);
      if (s2_fire && s2_drop_q && (drop_cnt_q != '1))
        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign bus_if.out_val          = s2_vld_q;
  assign bus_if.out_flowid       = s2_flowid_q;
  assign bus_if.out_accept       = s2_accept_q;
  assign bus_if.out_len          = s2_len_q;
  assign bus_if.out_payload_addr = s2_addr_q;
  assign bus_if.out_ack_pend     = s2_pend_q;
  assign bus_if.out_their_ack    = s2_ack_q;
  assign bus_if.out_our_win      = s2_win_q;

  assign st_wr_val  = s2_fire;
  assign st_wr_addr = s2_flowid_q;
  assign st_wr_ack  = s2_ack_q;
  assign st_wr_tail = s2_tail_q;

  assign stat_accept_cnt = acc_cnt_q;
  assign stat_drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_tcp_rx_seg_accept.sv
// Scoreboard bench for tcp_rx_seg_accept: directed segments push hand-computed results,
// a negedge monitor pops and compares each result as it retires.
module tb_tcp_rx_seg_accept;
  localparam int FW = 8;
  localparam int RXW = 14;
  localparam int PW = 15;
  localparam int LW = 16;
  localparam int AW = 32;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tcp_rx_seg_accept_if #(.FLOWID_W(FW), .RX_PTR_W(RXW), .LEN_W(LW), .ADDR_W(AW)) bus ();

  logic [FW-1:0] st_rd_addr, st_wr_addr;
  logic [31:0]   st_rd_ack, st_wr_ack;
  logic [PW-1:0] st_rd_tail, st_rd_head, st_wr_tail;
  logic          st_wr_val;
  logic [CW-1:0] stat_accept_cnt, stat_drop_cnt;

  tcp_rx_seg_accept #(.FLOWID_W(FW), .RX_PTR_W(RXW), .LEN_W(LW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus_if         (bus),
    .st_rd_addr     (st_rd_addr),
    .st_rd_ack      (st_rd_ack),
    .st_rd_tail     (st_rd_tail),
    .st_rd_head     (st_rd_head),
    .st_wr_val      (st_wr_val),
    .st_wr_addr     (st_wr_addr),
    .st_wr_ack      (st_wr_ack),
    .st_wr_tail     (st_wr_tail),
    .stat_accept_cnt(stat_accept_cnt),
    .stat_drop_cnt  (stat_drop_cnt)
  );

  // Per-flow state memory: 1-cycle read, old data on a read/write collision
  logic [31:0]   m_ack  [256];
  logic [PW-1:0] m_tail [256];
  logic [PW-1:0] m_head [256];
  logic          pl_en = 1'b0;
  logic [FW-1:0] pl_flow;
  logic [31:0]   pl_ack;
  logic [PW-1:0] pl_tail, pl_head;

  always @(posedge clk) begin
    st_rd_ack  <= m_ack[st_rd_addr];
    st_rd_tail <= m_tail[st_rd_addr];
    st_rd_head <= m_head[st_rd_addr];
    if (st_wr_val) begin
      m_ack[st_wr_addr]  <= st_wr_ack;
      m_tail[st_wr_addr] <= st_wr_tail;
    end
    if (pl_en) begin
      m_ack[pl_flow]  <= pl_ack;
      m_tail[pl_flow] <= pl_tail;
      m_head[pl_flow] <= pl_head;
    end
  end

  int cyc = 0;
  int wr_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (st_wr_val) wr_cnt <= wr_cnt + 1;

  typedef struct {
    logic [FW-1:0] flow;
    logic          accept;
    logic [LW-1:0] len;
    logic [AW-1:0] addr;
    logic          pend;
    logic [31:0]   ack;
    logic [PW-1:0] tail;
    logic [PW-1:0] win;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int exp_acc = 0;
  int exp_drop = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (bus.out_val && bus.out_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: flow 0x%0h retired with no expected entry", bus.out_flowid);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_flowid",       64'(bus.out_flowid),       64'(mon_e.flow));
        check("out_accept",       64'(bus.out_accept),       64'(mon_e.accept));
        check("out_len",          64'(bus.out_len),          64'(mon_e.len));
        check("out_payload_addr", 64'(bus.out_payload_addr), 64'(mon_e.addr));
        check("out_ack_pend",     64'(bus.out_ack_pend),     64'(mon_e.pend));
        check("out_their_ack",    64'(bus.out_their_ack),    64'(mon_e.ack));
        check("out_our_win",      64'(bus.out_our_win),      64'(mon_e.win));
        check("st_wr_val",        64'(st_wr_val),            64'd1);
        check("st_wr_addr",       64'(st_wr_addr),           64'(mon_e.flow));
        check("st_wr_ack",        64'(st_wr_ack),            64'(mon_e.ack));
        check("st_wr_tail",       64'(st_wr_tail),           64'(mon_e.tail));
        if (mon_e.cyc >= 0) check("latency_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic preload(input logic [FW-1:0] f, input logic [31:0] a,
                         input logic [PW-1:0] t, input logic [PW-1:0] h);
    pl_en = 1'b1; pl_flow = f; pl_ack = a; pl_tail = t; pl_head = h;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Present one segment, wait (bounded) for acceptance, push its expected result.
  task automatic send(input logic [FW-1:0] f, input logic [31:0] seq, input logic [LW-1:0] len,
                      input logic [AW-1:0] addr, input logic e_acc, input logic [LW-1:0] e_len,
                      input logic e_pend, input logic [31:0] e_ack, input logic [PW-1:0] e_tail,
                      input logic [PW-1:0] e_win, input bit chk_lat);
    exp_t e;
    int w = 0;
    bus.in_val = 1'b1;
    bus.in_flowid = f;
    bus.in_seq_num = seq;
    bus.in_payload_addr = addr;
    bus.in_payload_len = len;
    @(negedge clk);
    while (!bus.in_rdy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_rdy_timeout: flow 0x%0h never accepted", f);
    end else begin
      e.flow = f; e.accept = e_acc; e.len = e_len; e.addr = addr; e.pend = e_pend;
      e.ack = e_ack; e.tail = e_tail; e.win = e_win;
      e.cyc = chk_lat ? cyc + 2 : -1;
      exp_q.push_back(e);
      if (e_acc) exp_acc++;
      else if (len != '0) exp_drop++;
    end
    @(posedge clk); #1;
    bus.in_val = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results never emerged", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_base;
    bus.in_val = 1'b0;
    bus.in_flowid = '0;
    bus.in_seq_num = '0;
    bus.in_payload_addr = '0;
    bus.in_payload_len = '0;
    bus.out_rdy = 1'b1;
    @(posedge clk); #1;

    preload(8'd3,  32'd1000, 15'd0, 15'd0);
    preload(8'd9,  32'd1000, 15'd0, 15'd0);
    preload(8'd10, 32'd2000, 15'd500, 15'd500);
    preload(8'd12, 32'd3000, 15'd16334, 15'd0);
    preload(8'd13, 32'd4000, 15'd10, 15'd32760);
    preload(8'd14, 32'd6000, 15'd16484, 15'd100);
    preload(8'd15, 32'hFFFF_FFF0, 15'd0, 15'd0);
    preload(8'd7,  32'd5000, 15'd200, 15'd200);
    preload(8'd20, 32'd7000, 15'd0, 15'd0);

    @(negedge clk);
    check("rst_in_rdy",    64'(bus.in_rdy),       64'd0);
    check("rst_out_val",   64'(bus.out_val),      64'd0);
    check("rst_st_wr_val", 64'(st_wr_val),        64'd0);
    check("rst_acc_cnt",   64'(stat_accept_cnt),  64'd0);
    check("rst_drop_cnt",  64'(stat_drop_cnt),    64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_rdy", 64'(bus.in_rdy), 64'd1);
    @(posedge clk); #1;

    // Single in-order segment, 2-cycle latency
    send(8'd3, 32'd1000, 16'd100, 32'hA000_0000, 1'b1, 16'd100, 1'b1, 32'd1100, 15'd100, 15'd16284, 1'b1);
    drain();

    // Back-to-back on one flow exercises both forwarding paths
    preload(8'd3, 32'd1000, 15'd0, 15'd0);
    send(8'd3, 32'd1000, 16'd100, 32'hA000_0100, 1'b1, 16'd100, 1'b1, 32'd1100, 15'd100, 15'd16284, 1'b1);
    send(8'd3, 32'd1100, 16'd50,  32'hA000_0200, 1'b1, 16'd50,  1'b1, 32'd1150, 15'd150, 15'd16234, 1'b1);
    send(8'd3, 32'd1150, 16'd10,  32'hA000_0300, 1'b1, 16'd10,  1'b1, 32'd1160, 15'd160, 15'd16224, 1'b1);
    drain();

    // Out-of-order drop, zero-length, window overrun, pointer wrap, full buffer, sequence wrap
    send(8'd9,  32'd999,  16'd20, 32'hB000_0000, 1'b0, 16'd0, 1'b1, 32'd1000, 15'd0, 15'd16384, 1'b1);
    send(8'd10, 32'd2000, 16'd0,  32'hB000_0010, 1'b0, 16'd0, 1'b0, 32'd2000, 15'd500, 15'd16384, 1'b1);
`ifdef TCP_RX_TRIM_EN
    send(8'd12, 32'd3000, 16'd100, 32'hB000_0020, 1'b1, 16'd50, 1'b1, 32'd3050, 15'd16384, 15'd0, 1'b1);
`else
    send(8'd12, 32'd3000, 16'd100, 32'hB000_0020, 1'b0, 16'd0, 1'b1, 32'd3000, 15'd16334, 15'd50, 1'b1);
`endif
    send(8'd13, 32'd4000, 16'd16366, 32'hB000_0030, 1'b1, 16'd16366, 1'b1, 32'd20366, 15'd16376, 15'd0, 1'b1);
    send(8'd14, 32'd6000, 16'd1, 32'hB000_0040, 1'b0, 16'd0, 1'b1, 32'd6000, 15'd16484, 15'd0, 1'b1);
    send(8'd15, 32'hFFFF_FFF0, 16'd32, 32'hB000_0050, 1'b1, 16'd32, 1'b1, 32'h0000_0010, 15'd32, 15'd16352, 1'b1);
    drain();

    // Output back-pressure for 5 cycles with 3 segments on one flow
    bus.out_rdy = 1'b0;
    wr_base = wr_cnt;
    fork
      begin
        send(8'd7, 32'd5000, 16'd10, 32'hC000_0000, 1'b1, 16'd10, 1'b1, 32'd5010, 15'd210, 15'd16374, 1'b0);
        send(8'd7, 32'd5010, 16'd20, 32'hC000_0010, 1'b1, 16'd20, 1'b1, 32'd5030, 15'd230, 15'd16354, 1'b0);
        send(8'd7, 32'd5030, 16'd30, 32'hC000_0020, 1'b1, 16'd30, 1'b1, 32'd5060, 15'd260, 15'd16324, 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        check("stall_in_rdy",  64'(bus.in_rdy),  64'd0);
        check("stall_out_val", 64'(bus.out_val), 64'd1);
        check("stall_no_wr",   64'(wr_cnt),      64'(wr_base));
        @(posedge clk); #1;
        bus.out_rdy = 1'b1;
      end
    join
    drain();
    check("acc_cnt_mid",  64'(stat_accept_cnt), 64'(exp_acc));
    check("drop_cnt_mid", 64'(stat_drop_cnt),    64'(exp_drop));

    // Reset while S1 and S2 both hold segments
    bus.out_rdy = 1'b0;
    send(8'd20, 32'd7000, 16'd5, 32'hD000_0000, 1'b1, 16'd5, 1'b1, 32'd7005, 15'd5, 15'd16379, 1'b0);
    send(8'd20, 32'd7005, 16'd6, 32'hD000_0010, 1'b1, 16'd6, 1'b1, 32'd7011, 15'd11, 15'd16373, 1'b0);
    wr_base = wr_cnt;
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_acc = 0;
    exp_drop = 0;
    check("midrst_out_val",   64'(bus.out_val),     64'd0);
    check("midrst_st_wr_val", 64'(st_wr_val),       64'd0);
    check("midrst_in_rdy",    64'(bus.in_rdy),      64'd0);
    check("midrst_acc_cnt",   64'(stat_accept_cnt), 64'd0);
    check("midrst_drop_cnt",  64'(stat_drop_cnt),   64'd0);
    @(posedge clk); #1;
    bus.out_rdy = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_no_wr",      64'(wr_cnt),      64'(wr_base));
    check("midrst_out_val_2",  64'(bus.out_val), 64'd0);
    check("midrst_in_rdy_rel", 64'(bus.in_rdy),  64'd1);
    @(posedge clk); #1;
    send(8'd20, 32'd7000, 16'd5, 32'hD000_0020, 1'b1, 16'd5, 1'b1, 32'd7005, 15'd5, 15'd16379, 1'b1);
    drain();
    check("acc_cnt_end",  64'(stat_accept_cnt), 64'(exp_acc));
    check("drop_cnt_end", 64'(stat_drop_cnt),   64'(exp_drop));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
